// File: rtl/nx_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// nx_fifo_rd_stream
//
// Read-side adapter for an nx_fifo instance. Drains a first-word-fall-through
// FIFO through its ren/rdata/empty interface and presents the words as a
// valid/ready stream. A 2-entry skid buffer (head + skid) sustains one word
// per clock. The pop strobe to the FIFO is a function of buffer occupancy
// and FIFO flags only, so there is no combinational path from out_ready to
// fifo_ren.
//
// Optional feature macro: NX_FIFO_RD_STATS_EN
//   When defined, adds the xfer_cnt and stall_cnt statistics ports.
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset
//   fifo_empty  empty flag from the attached FIFO
//   fifo_rdata  FIFO head word (valid whenever fifo_empty = 0)
//   fifo_ren    FIFO pop strobe
//   fifo_clear  FIFO clear strobe (clear gated by reset)
//   clear       flush request for both FIFO and skid buffer
//   out_valid   stream word valid
//   out_ready   downstream accept
//   out_data    stream word, zero while out_valid = 0
//   buf_used    skid buffer occupancy, 0..2
//   xfer_cnt    delivered-word count   (NX_FIFO_RD_STATS_EN only)
//   stall_cnt   backpressure cycles    (NX_FIFO_RD_STATS_EN only)
//
// State table:
//   state   | meaning
//   S_EMPTY | no word buffered, out_valid low
//   S_ONE   | head holds the next word to deliver
//   S_FULL  | head and skid both hold words, FIFO reads stop
// ---------------------------------------------------------------------------
module nx_fifo_rd_stream #(
    parameter int WIDTH = 96
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_ren,
    output logic             fifo_clear,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       buf_used
`ifdef NX_FIFO_RD_STATS_EN
    ,
    output logic [31:0]      xfer_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;
    logic             push;
    logic             pop;

    // Encoding of state equals occupancy, so buf_used is the state itself.
    assign fifo_ren   = rst_n & ~clear & ~fifo_empty & (state != S_FULL);
    assign fifo_clear = clear & rst_n;
    assign push       = fifo_ren;
    assign out_valid  = (state != S_EMPTY);
    assign pop        = out_valid & out_ready;
    assign out_data   = out_valid ? head : '0;
    assign buf_used   = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else if (clear) begin
            // Slot contents are left stale; out_data is gated by out_valid.
            state <= S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (push) begin
                        head  <= fifo_rdata;
                        state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        head <= fifo_rdata;
                    end else if (push) begin
                        skid  <= fifo_rdata;
                        state <= S_FULL;
                    end else if (pop) begin
                        state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    // fifo_ren is low here, so only a pop can occur.
                    if (pop) begin
                        head  <= skid;
                        state <= S_ONE;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

`ifdef NX_FIFO_RD_STATS_EN
    // Zeroing on clear wins over a pop in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop && (xfer_cnt != 32'hFFFF_FFFF))
                xfer_cnt <= xfer_cnt + 32'd1;
            if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nx_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_nx_fifo_rd_stream
//
// Bench for nx_fifo_rd_stream. A queue models the attached FWFT FIFO; words
// loaded into it are also pushed onto the expected-word scoreboard and popped
// when the stream delivers a word. Checks are made mid-cycle, inputs are
// changed at the falling edge.
// ---------------------------------------------------------------------------
module tb_nx_fifo_rd_stream;

    localparam int W = 96;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fifo_empty;
    logic [W-1:0] fifo_rdata;
    logic         fifo_ren;
    logic         fifo_clear;
    logic         clear;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   buf_used;
`ifdef NX_FIFO_RD_STATS_EN
    logic [31:0]  xfer_cnt;
    logic [31:0]  stall_cnt;
`endif

    nx_fifo_rd_stream #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_ren   (fifo_ren),
        .fifo_clear (fifo_clear),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .buf_used   (buf_used)
`ifdef NX_FIFO_RD_STATS_EN
        ,
        .xfer_cnt   (xfer_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    typedef struct {
        logic       rdy;
        logic       v;
        logic [1:0] used;
        logic       ren;
        int         didx;
    } vec_t;

    vec_t         bp_tab[12];
    logic [W-1:0] words[5];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic load(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        drive_fifo();
    endtask

    function automatic logic [W-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    // Called just after a falling edge with inputs set; returns at the next
    // falling edge after the FIFO model has followed fifo_ren / fifo_clear.
    task automatic cycle();
        logic ren_s, clr_s;
        #1;
        chk("ren_while_empty", W'(fifo_ren & fifo_empty), '0);
        if (rst_n && out_valid === 1'b1 && out_ready) begin
            chk("spurious_word", W'(exp_q.size() == 0), '0);
            if (exp_q.size() != 0) chk("out_data_order", out_data, exp_q.pop_front());
        end
        ren_s = fifo_ren;
        clr_s = fifo_clear;
        @(posedge clk);
        if (clr_s) begin
            fifo_q.delete();
            exp_q.delete();
        end else if (ren_s && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
        end
        #1;
        drive_fifo();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 200) begin
            cycle();
            guard++;
        end
        chk(name, W'(guard >= 200), '0);
    endtask

    initial begin
        logic r1;
        int   sent;
        int   guard;
        logic [1:0] v_exp[6];

        rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0;
        drive_fifo();
        @(negedge clk);

        // Reset state, with clear requested while in reset.
        clear = 1'b1;
        #1;
        chk("rst_fifo_clear", W'(fifo_clear), '0);
        chk("rst_fifo_ren", W'(fifo_ren), '0);
        cycle();
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_buf_used", W'(buf_used), '0);
        clear = 1'b0;

        // Four preloaded words streamed with out_ready held high.
        fifo_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) load(W'(96'hA0A0_0000_0000_0000_0000_0000) + W'(i));
        do_reset();
        v_exp = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("stream_valid_c%0d", i), W'(out_valid), W'(v_exp[i][0]));
            cycle();
        end

        // Backpressure: 5 words, out_ready low for 6 cycles then high.
        bp_tab[0]  = '{1'b0, 1'b0, 2'd0, 1'b1, -1};
        bp_tab[1]  = '{1'b0, 1'b1, 2'd1, 1'b1, 0};
        bp_tab[2]  = '{1'b0, 1'b1, 2'd2, 1'b0, 0};
        bp_tab[3]  = '{1'b0, 1'b1, 2'd2, 1'b0, 0};
        bp_tab[4]  = '{1'b0, 1'b1, 2'd2, 1'b0, 0};
        bp_tab[5]  = '{1'b0, 1'b1, 2'd2, 1'b0, 0};
        bp_tab[6]  = '{1'b1, 1'b1, 2'd2, 1'b0, 0};
        bp_tab[7]  = '{1'b1, 1'b1, 2'd1, 1'b1, 1};
        bp_tab[8]  = '{1'b1, 1'b1, 2'd1, 1'b1, 2};
        bp_tab[9]  = '{1'b1, 1'b1, 2'd1, 1'b1, 3};
        bp_tab[10] = '{1'b1, 1'b1, 2'd1, 1'b0, 4};
        bp_tab[11] = '{1'b1, 1'b0, 2'd0, 1'b0, -1};
        fifo_q.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            words[i] = rand_word();
            load(words[i]);
        end
        do_reset();
        for (int i = 0; i < 12; i++) begin
            out_ready = bp_tab[i].rdy;
            #1;
            chk($sformatf("bp_valid_c%0d", i), W'(out_valid), W'(bp_tab[i].v));
            chk($sformatf("bp_used_c%0d", i), W'(buf_used), W'(bp_tab[i].used));
            chk($sformatf("bp_ren_c%0d", i), W'(fifo_ren), W'(bp_tab[i].ren));
            chk($sformatf("bp_data_c%0d", i), out_data,
                (bp_tab[i].didx < 0) ? '0 : words[bp_tab[i].didx]);
            cycle();
        end

        // Random backpressure over 1000 random words.
        fifo_q.delete(); exp_q.delete();
        do_reset();
        sent = 0;
        guard = 0;
        while ((sent < 1000 || exp_q.size() != 0) && guard < 20000) begin
            if (sent < 1000 && fifo_q.size() < 8 && $urandom_range(1, 0) == 1) begin
                load(rand_word());
                sent++;
            end
            out_ready = 1'($urandom_range(1, 0));
            if (guard % 37 == 0) begin
                #1;
                r1 = fifo_ren;
                out_ready = ~out_ready;
                #1;
                chk("ren_indep_of_ready", W'(fifo_ren), W'(r1));
                out_ready = ~out_ready;
            end
            cycle();
            guard++;
        end
        chk("random_timeout", W'(guard >= 20000), '0);

        // Clear with two words buffered and three still in the FIFO.
        fifo_q.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            words[i] = rand_word();
            load(words[i]);
        end
        do_reset();
        cycle();
        cycle();
        #1;
        chk("clr_pre_used", W'(buf_used), W'(2));
        chk("clr_pre_fifo_level", W'(fifo_q.size()), W'(3));
        clear = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("clr_fifo_clear", W'(fifo_clear), W'(1));
        chk("clr_fifo_ren", W'(fifo_ren), '0);
        cycle();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("clr_valid_c%0d", i), W'(out_valid), '0);
            chk($sformatf("clr_data_c%0d", i), out_data, '0);
            cycle();
        end
        load(rand_word());
        load(rand_word());
        drain("clr_drain_timeout");

        // Reset with two words buffered.
        fifo_q.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            words[i] = rand_word();
            load(words[i]);
        end
        do_reset();
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ren", W'(fifo_ren), '0);
        cycle();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_valid", W'(out_valid), '0);
        chk("mid_rst_used", W'(buf_used), '0);
        chk("mid_rst_fifo_head", fifo_q[0], words[2]);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        drain("mid_rst_drain_timeout");

`ifdef NX_FIFO_RD_STATS_EN
        // 10 transfers and 7 stall cycles, then clear.
        fifo_q.delete(); exp_q.delete();
        for (int i = 0; i < 10; i++) load(rand_word());
        do_reset();
        for (int i = 0; i < 8; i++) cycle();
        drain("stats_drain_timeout");
        #1;
        chk("stats_xfer", W'(xfer_cnt), W'(10));
        chk("stats_stall", W'(stall_cnt), W'(7));
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        #1;
        chk("stats_xfer_clr", W'(xfer_cnt), '0);
        chk("stats_stall_clr", W'(stall_cnt), '0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nx_fifo_rd_stream.md
# nx_fifo_rd_stream

Read-side adapter for an `nx_fifo` instance. It drains a first-word-fall-through FIFO through the FIFO's `ren`/`rdata`/`empty` interface and presents the words as a registered valid/ready stream. A 2-entry skid buffer sustains one word per clock with no combinational path from `out_ready` to `fifo_ren`. It sits between any `nx_fifo` and a downstream pipeline stage that applies backpressure.

## Interface
Parameters:
- `WIDTH`, 96, data width in bits; must equal the attached FIFO's width.

Ports (one clock domain; reset is synchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset, sampled on `posedge clk`
- `fifo_empty`  in  1  empty flag from the attached FIFO
- `fifo_rdata`  in  WIDTH  FIFO head word, valid in the same cycle whenever `fifo_empty`=0
- `fifo_ren`  out  1  FIFO pop strobe
- `fifo_clear`  out  1  FIFO clear strobe
- `clear`  in  1  flush request that empties both the FIFO and the skid buffer
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  downstream accept
- `out_data`  out  WIDTH  stream word; all zeros whenever `out_valid`=0
- `buf_used`  out  2  skid occupancy, 0..2
- `xfer_cnt`  out  32  delivered-word count; present only with `NX_FIFO_RD_STATS_EN`
- `stall_cnt`  out  32  backpressure-cycle count; present only with `NX_FIFO_RD_STATS_EN`

## Operation
- State: a 2-bit occupancy `cnt` and two slots. `head` drives `out_data`; `skid` holds the second word.
- `fifo_ren = rst_n & !clear & !fifo_empty & (cnt != 2)`. The term depends only on registered state and FIFO flags, never on `out_ready`. The block never pops an empty FIFO.
- `fifo_clear = clear & rst_n` (combinational pass-through).
- A push occurs when `fifo_ren`=1; the word is taken from `fifo_rdata` in that cycle.
- A pop occurs when `out_valid & out_ready`.
- `out_valid = (cnt != 0)`; `buf_used = cnt`.
- Next state, pushes and pops in the same cycle:
  - cnt 0, push: `head` <= rdata, cnt 1.
  - cnt 1, push only: `skid` <= rdata, cnt 2.
  - cnt 1, pop only: cnt 0.
  - cnt 1, push and pop: `head` <= rdata, cnt 1.
  - cnt 2, pop: `head` <= `skid`, cnt 1. No push is possible at cnt 2.
- `clear` has priority over push and pop.
  - cnt goes to 0 next cycle and the slot contents are don't-care.
  - A handshake (`out_valid & out_ready`) on the `clear` cycle still counts as delivered.
- Words leave in exact FIFO order; none are duplicated or dropped except by `clear`.

## Timing
- Reset (`rst_n`=0 at a `posedge clk`): cnt 0, so `out_valid` 0, `out_data` 0 and `buf_used` 0.
- While `rst_n`=0, `fifo_ren` and `fifo_clear` are held at 0. Stats counters reset to 0.
- Reset mid-transfer discards buffered words. FIFO contents are untouched unless `clear` is also used.
- Latency: a word that is FIFO head in cycle N (`fifo_empty`=0, cnt<2) is on `out_data` with `out_valid`=1 in cycle N+1.
- Throughput: 1 word/clk while `out_ready`=1 and the FIFO is non-empty. Steady state is cnt=1.
- Backpressure: with `out_ready`=0, the block absorbs at most 2 words, then `fifo_ren` drops.
- `out_data` and `out_valid` stay stable while `out_valid & !out_ready`.
- After `clear` in cycle N: `out_valid`=0 in cycle N+1. Reads resume in N+1 if the FIFO is non-empty.

## Configuration
- `NX_FIFO_RD_STATS_EN` defined:
  - adds `xfer_cnt`, which increments on each pop;
  - adds `stall_cnt`, which increments on each cycle with `out_valid & !out_ready`;
  - both are 32-bit, saturate at 0xFFFFFFFF, and are zeroed by reset or `clear`;
  - a pop on the `clear` cycle is not added, because the zeroing takes priority.
- Not defined: both ports and their counters are absent. All other behaviour is identical.

## Test plan
- Reset, then FIFO preloaded with 4 words A,B,C,D and `out_ready`=1 constantly -> `out_valid` rises 1 cycle after reset release; A,B,C,D on 4 consecutive cycles; `fifo_ren` never high while `fifo_empty`=1.
- FIFO holds 5 words, `out_ready`=0 for 6 cycles, then 1 -> `buf_used` reaches 2 and `fifo_ren` falls; `out_data` holds word 1 stable; all 5 words then delivered in order with no gaps.
- Random `out_ready` (50%) over 1000 random 96-bit words -> output sequence equals input sequence; no comb dependency of `fifo_ren` on `out_ready` (checked by toggling `out_ready` mid-cycle).
- `clear` pulsed with cnt=2 and 3 words still in the FIFO -> `fifo_clear`=1 in the same cycle, `out_valid`=0 and `out_data`=0 next cycle, no stale words emitted afterward.
- `rst_n` asserted with cnt=2 -> next cycle `out_valid`=0, `buf_used`=0; FIFO head word is the one following the last word pushed before reset.
- With `NX_FIFO_RD_STATS_EN`: 10 transfers plus 7 stall cycles -> `xfer_cnt`=10, `stall_cnt`=7; after `clear` both read 0.
